// File: rtl/line_card_xbar_requester.sv
// line_card_xbar_requester: holds a frame's first beat, requests a crossbar
// path for its destination mask, streams the frame on grant, then releases.
module line_card_xbar_requester #(
  parameter int GRANT_TIMEOUT = 1024,
  parameter int TIMEOUT_WIDTH = 11,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tvalid,
  output logic                 rx_tready,
  input  logic [63:0]          rx_tdata,
  input  logic [7:0]           rx_tkeep,
  input  logic                 rx_tlast,
  input  logic [10:0]          rx_tdest,
  input  logic [11:0]          rx_tuser,
  output logic                 xbar_req,
  output logic [10:0]          xbar_req_dest,
  input  logic                 xbar_grant,
  output logic                 xbar_release,
  output logic                 tx_tvalid,
  input  logic                 tx_tready,
  output logic [63:0]          tx_tdata,
  output logic [7:0]           tx_tkeep,
  output logic                 tx_tlast,
  output logic [11:0]          tx_tuser,
  output logic [CNT_WIDTH-1:0] frames_forwarded,
  output logic [CNT_WIDTH-1:0] frames_dropped_nodest,
  output logic [CNT_WIDTH-1:0] frames_dropped_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    FORWARD,
    DROP
  } state_e;

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST =
    TIMEOUT_WIDTH'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [10:0]            dest_q, dest_d;
  logic [11:0]            vlan_q, vlan_d;
  logic                   req_q, req_d;
  logic                   rel_q, rel_d;
  logic [CNT_WIDTH-1:0]   fwd_q, fwd_d;
  logic [CNT_WIDTH-1:0]   nod_q, nod_d;
  logic [CNT_WIDTH-1:0]   tmc_q, tmc_d;
  logic                   inc_fwd, inc_nod, inc_tmo;
  logic                   in_fwd;

  // Frame FSM: next state, latches, handshake steering and counter events
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    dest_d    = dest_q;
    vlan_d    = vlan_q;
    rel_d     = 1'b0;
    inc_fwd   = 1'b0;
    inc_nod   = 1'b0;
    inc_tmo   = 1'b0;
    rx_tready = 1'b0;
    tx_tvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_tvalid) begin
          dest_d = rx_tdest;
          vlan_d = rx_tuser;
          tmo_d  = '0;
          if (rx_tdest == '0) begin
            state_d = DROP;
            inc_nod = 1'b1;
          end else begin
            state_d = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (xbar_grant) begin
          state_d = FORWARD;
        end else if (tmo_q == TMO_LAST) begin
          state_d = DROP;
          inc_tmo = 1'b1;
        end else begin
          tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
        end
      end
      FORWARD: begin
        tx_tvalid = rx_tvalid;
        rx_tready = tx_tready;
        if (rx_tvalid && tx_tready && rx_tlast) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          inc_fwd = 1'b1;
        end
      end
      DROP: begin
        rx_tready = 1'b1;
        if (rx_tvalid && rx_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQUEST);
  end

  // Saturating statistics counters
  always_comb begin
    fwd_d = fwd_q;
    nod_d = nod_q;
    tmc_d = tmc_q;
    if (inc_fwd && fwd_q != CNT_MAX) fwd_d = fwd_q + CNT_WIDTH'(1);
    if (inc_nod && nod_q != CNT_MAX) nod_d = nod_q + CNT_WIDTH'(1);
    if (inc_tmo && tmc_q != CNT_MAX) tmc_d = tmc_q + CNT_WIDTH'(1);
  end

  // State, latched frame context, request/release and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      dest_q  <= '0;
      vlan_q  <= '0;
      req_q   <= 1'b0;
      rel_q   <= 1'b0;
      fwd_q   <= '0;
      nod_q   <= '0;
      tmc_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      dest_q  <= dest_d;
      vlan_q  <= vlan_d;
      req_q   <= req_d;
      rel_q   <= rel_d;
      fwd_q   <= fwd_d;
      nod_q   <= nod_d;
      tmc_q   <= tmc_d;
    end
  end

  assign in_fwd = (state_q == FORWARD);

  assign tx_tdata  = in_fwd ? rx_tdata : '0;
  assign tx_tkeep  = in_fwd ? rx_tkeep : '0;
  assign tx_tlast  = in_fwd ? rx_tlast : 1'b0;
  assign tx_tuser  = vlan_q;

  assign xbar_req      = req_q;
  assign xbar_req_dest = dest_q;
  assign xbar_release  = rel_q;

  assign frames_forwarded       = fwd_q;
  assign frames_dropped_nodest  = nod_q;
  assign frames_dropped_timeout = tmc_q;

endmodule

// File: tb/tb_line_card_xbar_requester.sv
// tb_line_card_xbar_requester: scoreboard bench for the crossbar requester,
// small timeout and narrow counters so saturation is reachable.
module tb_line_card_xbar_requester;

  localparam int GT = 16;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_tvalid, rx_tready;
  logic [63:0]   rx_tdata;
  logic [7:0]    rx_tkeep;
  logic          rx_tlast;
  logic [10:0]   rx_tdest;
  logic [11:0]   rx_tuser;
  logic          xbar_req;
  logic [10:0]   xbar_req_dest;
  logic          xbar_grant;
  logic          xbar_release;
  logic          tx_tvalid, tx_tready;
  logic [63:0]   tx_tdata;
  logic [7:0]    tx_tkeep;
  logic          tx_tlast;
  logic [11:0]   tx_tuser;
  logic [CW-1:0] frames_forwarded;
  logic [CW-1:0] frames_dropped_nodest;
  logic [CW-1:0] frames_dropped_timeout;

  always #5 clk = ~clk;

  line_card_xbar_requester #(
    .GRANT_TIMEOUT(GT),
    .TIMEOUT_WIDTH(5),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_tvalid(rx_tvalid),
    .rx_tready(rx_tready),
    .rx_tdata(rx_tdata),
    .rx_tkeep(rx_tkeep),
    .rx_tlast(rx_tlast),
    .rx_tdest(rx_tdest),
    .rx_tuser(rx_tuser),
    .xbar_req(xbar_req),
    .xbar_req_dest(xbar_req_dest),
    .xbar_grant(xbar_grant),
    .xbar_release(xbar_release),
    .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready),
    .tx_tdata(tx_tdata),
    .tx_tkeep(tx_tkeep),
    .tx_tlast(tx_tlast),
    .tx_tuser(tx_tuser),
    .frames_forwarded(frames_forwarded),
    .frames_dropped_nodest(frames_dropped_nodest),
    .frames_dropped_timeout(frames_dropped_timeout)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [11:0] u;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;

  int n_vec = 0;
  int n_err = 0;

  int grant_lat = -1;
  int req_cyc = 0;
  int req_len = 0;
  int req_total = 0;
  logic [10:0] req_dest_seen = '0;

  bit   tog_mode = 1'b0;
  int   ph = 0;
  logic [3:0] pat = 4'b1001;

  logic last_hs_prev = 1'b0;
  int   rel_pulses = 0;

  int e_fwd = 0;
  int e_nod = 0;
  int e_tmo = 0;
  int e_rel = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic chk_counters();
    chk("cnt_fwd", 64'(frames_forwarded), 64'(sat(e_fwd)));
    chk("cnt_nod", 64'(frames_dropped_nodest), 64'(sat(e_nod)));
    chk("cnt_tmo", 64'(frames_dropped_timeout), 64'(sat(e_tmo)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame beat by beat; stop < nb leaves the frame unfinished.
  task automatic send_frame(input logic [10:0] dest, input logic [11:0] user,
                            input int nb, input int stop, input bit fwd,
                            output int cyc);
    beat_t bt;
    bit    got;
    cyc = 0;
    for (int i = 0; i < stop; i++) begin
      bt.d = {$urandom, $urandom};
      bt.k = (i == nb - 1) ? (8'hFF >> $urandom_range(7, 0)) : 8'hFF;
      bt.l = (i == nb - 1);
      bt.u = user;
      rx_tdata  = bt.d;
      rx_tkeep  = bt.k;
      rx_tlast  = bt.l;
      rx_tdest  = (i == 0) ? dest : 11'h7AA;
      rx_tuser  = (i == 0) ? user : 12'hBAD;
      rx_tvalid = 1'b1;
      if (fwd) exp_q.push_back(bt);
      got = 1'b0;
      do begin
        @(negedge clk);
        cyc++;
        got = rx_tready;
        if (!fwd) chk("drop_txv", 64'(tx_tvalid), 64'd0);
        @(posedge clk);
        #1;
      end while (!got && cyc < 300);
      if (!got) begin
        chk("src_stall", 64'd0, 64'd1);
        break;
      end
    end
    if (stop == nb) rx_tvalid = 1'b0;
  endtask

  // Crossbar model: grants grant_lat cycles after request rises
  initial begin
    xbar_grant = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        req_cyc = 0;
        xbar_grant = 1'b0;
      end else if (xbar_req) begin
        req_cyc++;
        req_total++;
        req_dest_seen = xbar_req_dest;
        xbar_grant = (grant_lat >= 0) && (req_cyc == grant_lat + 1);
      end else begin
        if (req_cyc > 0) req_len = req_cyc;
        req_cyc = 0;
        xbar_grant = 1'b0;
      end
    end
  end

  // Downstream ready: steady high or the 1,0,0,1 pattern
  initial begin
    tx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_tready = tog_mode ? pat[ph % 4] : 1'b1;
      ph++;
    end
  end

  // Output monitor: scoreboard pop, ready mirroring, release pulse timing
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_tvalid) chk("rdy_mirror", 64'(rx_tready), 64'(tx_tready));
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          mon_b = exp_q.pop_front();
          chk("tdata", tx_tdata, mon_b.d);
          chk("tkeep", 64'(tx_tkeep), 64'(mon_b.k));
          chk("tlast", 64'(tx_tlast), 64'(mon_b.l));
          chk("tuser", 64'(tx_tuser), 64'(mon_b.u));
        end
      end
      if (last_hs_prev || xbar_release)
        chk("release", 64'(xbar_release), 64'(last_hs_prev));
      if (xbar_release) rel_pulses++;
      last_hs_prev = tx_tvalid && tx_tready && tx_tlast;
    end else begin
      last_hs_prev = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    int rt0;
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
    rx_tkeep  = '0;
    rx_tlast  = 1'b0;
    rx_tdest  = '0;
    rx_tuser  = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_rx_tready", 64'(rx_tready), 64'd0);
    chk("rst_tx_tvalid", 64'(tx_tvalid), 64'd0);
    chk("rst_xbar_req", 64'(xbar_req), 64'd0);
    chk("rst_req_dest", 64'(xbar_req_dest), 64'd0);
    chk("rst_release", 64'(xbar_release), 64'd0);
    chk("rst_tx_tuser", 64'(tx_tuser), 64'd0);
    chk_counters();
    #21 rst = 1'b0;
    @(posedge clk);
    #1;

    grant_lat = 5;
    send_frame(11'h004, 12'd69, 3, 3, 1'b1, cyc);
    e_fwd++;
    e_rel++;
    chk("f1_cycles", 64'(cyc), 64'd10);
    chk("f1_req_len", 64'(req_len), 64'd6);
    chk("f1_req_dest", 64'(req_dest_seen), 64'h004);
    idle(2);
    chk_counters();

    rt0 = req_total;
    send_frame(11'h000, 12'd5, 4, 4, 1'b0, cyc);
    e_nod++;
    chk("nod_cycles", 64'(cyc), 64'd5);
    chk("nod_no_req", 64'(req_total - rt0), 64'd0);
    idle(2);
    chk_counters();

    grant_lat = -1;
    send_frame(11'h7FF, 12'd7, 3, 3, 1'b0, cyc);
    e_tmo++;
    chk("tmo_cycles", 64'(cyc), 64'(1 + GT + 3));
    chk("tmo_req_len", 64'(req_len), 64'(GT));
    idle(2);
    chk_counters();

    grant_lat = GT - 1;
    send_frame(11'h300, 12'd100, 2, 2, 1'b1, cyc);
    e_fwd++;
    e_rel++;
    chk("edge_cycles", 64'(cyc), 64'(1 + GT + 2));
    chk("edge_req_len", 64'(req_len), 64'(GT));
    chk("edge_req_dest", 64'(req_dest_seen), 64'h300);
    idle(2);
    chk_counters();

    tog_mode = 1'b1;
    grant_lat = 0;
    send_frame(11'h001, 12'hABC, 7, 7, 1'b1, cyc);
    tog_mode = 1'b0;
    e_fwd++;
    e_rel++;
    idle(2);
    chk_counters();

    grant_lat = 2;
    send_frame(11'h010, 12'd1, 1, 1, 1'b1, cyc);
    e_fwd++;
    e_rel++;
    chk("single_cycles", 64'(cyc), 64'd5);
    idle(2);
    chk_counters();

    grant_lat = 0;
    send_frame(11'h020, 12'd2, 2, 2, 1'b1, cyc);
    send_frame(11'h040, 12'd3, 1, 1, 1'b1, cyc);
    e_fwd += 2;
    e_rel += 2;
    chk("b2b_cycles", 64'(cyc), 64'd3);
    idle(2);
    chk_counters();

    for (int i = 0; i < 3; i++) begin
      send_frame(11'h000, 12'(i), 1, 1, 1'b0, cyc);
      e_nod++;
      chk("nod1_cycles", 64'(cyc), 64'd2);
      idle(1);
      chk_counters();
    end

    grant_lat = -1;
    send_frame(11'h002, 12'd9, 1, 1, 1'b0, cyc);
    e_tmo++;
    chk("tmo1_cycles", 64'(cyc), 64'(1 + GT + 1));
    idle(2);
    chk_counters();

    grant_lat = 0;
    send_frame(11'h080, 12'd33, 6, 2, 1'b1, cyc);
    #2 rst = 1'b1;
    #1;
    chk("mid_rx_tready", 64'(rx_tready), 64'd0);
    chk("mid_tx_tvalid", 64'(tx_tvalid), 64'd0);
    chk("mid_tx_tdata", tx_tdata, 64'd0);
    chk("mid_xbar_req", 64'(xbar_req), 64'd0);
    chk("mid_release", 64'(xbar_release), 64'd0);
    chk("mid_tx_tuser", 64'(tx_tuser), 64'd0);
    e_fwd = 0;
    e_nod = 0;
    e_tmo = 0;
    chk_counters();
    rx_tvalid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_tx_tvalid", 64'(tx_tvalid), 64'd0);
    chk("post_release", 64'(xbar_release), 64'd0);
    grant_lat = 1;
    send_frame(11'h100, 12'd44, 2, 2, 1'b1, cyc);
    e_fwd++;
    e_rel++;
    chk("post_cycles", 64'(cyc), 64'd5);
    idle(3);
    chk_counters();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("rel_pulses", 64'(rel_pulses), 64'(e_rel));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
